// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
// Elastic pipeline-stage register carrying a control bundle and a data bundle
// under a valid/ready handshake. It replaces the fixed IF/ID/EX/MEM latches.
//
// With SKID=1 the stage holds up to two entries (main + skid), and in_ready
// comes straight from a flop, so upstream ready timing is cut. With SKID=0 it
// holds a single entry, and in_ready is combinational from out_ready.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous active-high reset, overrides everything
//   flush      in   1       drop every held entry and any entry arriving this edge
//   in_valid   in   1       upstream presents an entry
//   in_ready   out  1       stage accepts an entry this cycle
//   in_ctrl    in   CTRL_W  upstream control bundle
//   in_data    in   DATA_W  upstream data bundle
//   out_valid  out  1       out_ctrl/out_data hold a valid entry
//   out_ready  in   1       downstream consumes the entry this cycle
//   out_ctrl   out  CTRL_W  head control, CTRL_NOP while out_valid=0 (bubble)
//   out_data   out  DATA_W  head data; 0 after reset/flush, else last held value
//   occupancy  out  2       number of entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned        CTRL_W   = 32'd8,
    parameter int unsigned        DATA_W   = 32'd128,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = {CTRL_W{1'b0}},
    parameter bit                 SKID     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;

    logic              out_valid_r;
    logic              in_ready_r;
    logic [1:0]        occ_r;

    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;

    logic              in_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              load_in_s;     // main <= incoming entry
    logic              promote_s;     // main <= skid entry
    logic              load_skid_s;   // skid <= incoming entry
    logic              clear_s;       // flush: return datapath to bubble values

    // Entry count encoded by each state.
    function automatic logic [1:0] occ_of(input state_t st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

    // SKID=1 keeps ready registered; SKID=0 lets a consuming downstream
    // free the single slot in the same cycle.
    assign in_ready_s = SKID ? in_ready_r : (!out_valid_r || out_ready);

    assign push_s = in_valid && in_ready_s;
    assign pop_s  = out_valid_r && out_ready;

    // Next-state and datapath load selection.
    always_comb begin
        state_s     = state_r;
        load_in_s   = 1'b0;
        promote_s   = 1'b0;
        load_skid_s = 1'b0;
        clear_s     = 1'b0;
        if (flush) begin
            // A transfer-out on this edge was still consumed downstream;
            // an entry accepted on this edge is simply never stored.
            state_s = ST_EMPTY;
            clear_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_s   = ST_ONE;
                        load_in_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_s   = ST_ONE;
                        load_in_s = 1'b1;
                    end else if (push_s && SKID) begin
                        state_s     = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (pop_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        // Without a skid slot, push implies pop in this state.
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s) begin
                        state_s   = ST_ONE;
                        promote_s = 1'b1;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                    clear_s = 1'b1;
                end
            endcase
        end
    end

    // State register plus flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
        end else begin
            state_r     <= state_s;
            out_valid_r <= (state_s != ST_EMPTY);
            in_ready_r  <= (state_s != ST_TWO);
            occ_r       <= occ_of(state_s);
        end
    end

    // Main and skid entry registers.
    always_ff @(posedge clk) begin
        if (rst || clear_s) begin
            main_ctrl_r <= CTRL_NOP;
            main_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= CTRL_NOP;
            skid_data_r <= {DATA_W{1'b0}};
        end else begin
            if (load_in_s) begin
                main_ctrl_r <= in_ctrl;
                main_data_r <= in_data;
            end else if (promote_s) begin
                main_ctrl_r <= skid_ctrl_r;
                main_data_r <= skid_data_r;
            end else begin
                main_ctrl_r <= main_ctrl_r;
                main_data_r <= main_data_r;
            end
            if (load_skid_s) begin
                skid_ctrl_r <= in_ctrl;
                skid_data_r <= in_data;
            end else begin
                skid_ctrl_r <= skid_ctrl_r;
                skid_data_r <= skid_data_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    // A stale main register must never leak control onto an empty stage.
    assign out_ctrl  = out_valid_r ? main_ctrl_r : CTRL_NOP;
    assign out_data  = main_data_r;
    assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// Testbench for pipe_stage_skid: a SKID=1 instance (CTRL_NOP=A5) and a SKID=0
// instance (CTRL_NOP=3C), both checked against a FIFO-queue reference model.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int CW = 8;
    localparam int DW = 128;
    localparam logic [CW-1:0] NOP1 = 8'hA5;
    localparam logic [CW-1:0] NOP0 = 8'h3C;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    // SKID=1 instance
    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    // SKID=0 instance
    logic          flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [CW-1:0] in_ctrl0, out_ctrl0;
    logic [DW-1:0] in_data0, out_data0;
    logic [1:0]    occupancy0;

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;

    int checks = 0;
    int errors = 0;

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_NOP(NOP1), .SKID(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CTRL_NOP(NOP0), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .occupancy(occupancy0)
    );

    always #5 clk = ~clk;

    // Reference model views: a bounded FIFO, head visible at the output.
    function automatic logic m1_valid();          return q1.size() != 0; endfunction
    function automatic logic [CW-1:0] m1_ctrl();  return (q1.size() != 0) ? q1[0].ctrl : NOP1; endfunction
    function automatic logic [DW-1:0] m1_data();  return (q1.size() != 0) ? q1[0].data : last1; endfunction
    function automatic logic [1:0] m1_occ();      return 2'(q1.size()); endfunction
    function automatic logic m1_ready();          return q1.size() < 2; endfunction

    function automatic logic m0_valid();          return q0.size() != 0; endfunction
    function automatic logic [CW-1:0] m0_ctrl();  return (q0.size() != 0) ? q0[0].ctrl : NOP0; endfunction
    function automatic logic [DW-1:0] m0_data();  return (q0.size() != 0) ? q0[0].data : last0; endfunction
    function automatic logic [1:0] m0_occ();      return 2'(q0.size()); endfunction
    function automatic logic m0_ready();          return (q0.size() == 0) || out_ready0; endfunction

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock edge for both instances; model advances with the inputs seen before the edge.
    task automatic tick();
        ent_t e1, e0;
        logic push1, pop1, push0, pop0, r, f1, f0;
        e1.ctrl = in_ctrl;  e1.data = in_data;
        e0.ctrl = in_ctrl0; e0.data = in_data0;
        push1 = in_valid && m1_ready();
        pop1  = m1_valid() && out_ready;
        push0 = in_valid0 && m0_ready();
        pop0  = m0_valid() && out_ready0;
        r = rst; f1 = flush; f0 = flush0;
        @(posedge clk);
        #1;
        if (r || f1) begin
            q1.delete(); last1 = '0;
        end else begin
            if (pop1) void'(q1.pop_front());
            if (push1) q1.push_back(e1);
            if (q1.size() != 0) last1 = q1[0].data;
        end
        if (r || f0) begin
            q0.delete(); last0 = '0;
        end else begin
            if (pop0) void'(q0.pop_front());
            if (push0) q0.push_back(e0);
            if (q0.size() != 0) last0 = q0[0].data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'hA5 || out_data !== '0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL reset skid1: valid=%b ctrl=%h data=%h rdy=%b occ=%0d, want 0 a5 0 1 0",
                     out_valid, out_ctrl, out_data, in_ready, occupancy);
        end
        checks++;
        if (out_valid0 !== 1'b0 || out_ctrl0 !== 8'h3C || out_data0 !== '0 || in_ready0 !== 1'b1 || occupancy0 !== 2'd0) begin
            errors++;
            $display("FAIL reset skid0: valid=%b ctrl=%h data=%h rdy=%b occ=%0d, want 0 3c 0 1 0",
                     out_valid0, out_ctrl0, out_data0, in_ready0, occupancy0);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] b;
        out_ready = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            b = v[7:0];
            in_valid = 1'b1; in_ctrl = b; in_data = {16{b}};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== b || out_data !== {16{b}} || occupancy !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream v=%0d: valid=%b ctrl=%h occ=%0d rdy=%b, want 1 %h 1 1",
                         v, out_valid, out_ctrl, occupancy, in_ready, b);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== NOP1 || out_data !== {16{8'h10}} || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: valid=%b ctrl=%h occ=%0d data=%h, want 0 a5 0 held 10s",
                     out_valid, out_ctrl, occupancy, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] want [3];
        logic [7:0] vals [3];
        int idx;
        want = '{8'h11, 8'h22, 8'h33};
        vals = '{8'h11, 8'h22, 8'h33};
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ctrl = vals[i]; in_data = {16{vals[i]}};
            tick();
        end
        in_ctrl = vals[2]; in_data = {16{vals[2]}};
        tick();
        checks++;
        if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_ctrl !== 8'h11 || out_data !== {16{8'h11}}) begin
            errors++;
            $display("FAIL bp_full: rdy=%b occ=%0d ctrl=%h, want 0 2 11", in_ready, occupancy, out_ctrl);
        end
        // Release: consume one entry per cycle, upstream keeps 0x33 until accepted.
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 8 && idx < 3; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== want[idx]) begin
                errors++;
                $display("FAIL bp_order idx=%0d: valid=%b ctrl=%h, want 1 %h", idx, out_valid, out_ctrl, want[idx]);
            end
            if (in_valid && m1_ready()) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
            idx++;
        end
        checks++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || idx != 3) begin
            errors++;
            $display("FAIL bp_empty: valid=%b occ=%0d seen=%0d, want 0 0 3", out_valid, occupancy, idx);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ctrl = 8'($urandom); in_data = rnd_data();
            tick();
        end
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 8'h44; in_data = {16{8'h44}};
        tick();
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== NOP1 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_two: occ=%0d valid=%b ctrl=%h data=%h rdy=%b, want 0 0 a5 0 1",
                     occupancy, out_valid, out_ctrl, out_data, in_ready);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_ctrl === 8'h44) begin
                errors++;
                $display("FAIL flush_ghost c=%0d: valid=%b ctrl=%h, want 0 a5", c, out_valid, out_ctrl);
            end
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== NOP1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: occ=%0d valid=%b ctrl=%h rdy=%b", occupancy, out_valid, out_ctrl, in_ready);
        end
    endtask

    task automatic test_random_skid();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_ctrl   = 8'($urandom);
            in_data   = rnd_data();
            tick();
            checks++;
            if (out_valid !== m1_valid() || out_ctrl !== m1_ctrl() || out_data !== m1_data() ||
                occupancy !== m1_occ() || in_ready !== m1_ready()) begin
                errors++;
                $display("FAIL rand1 c=%0d: valid=%b ctrl=%h occ=%0d rdy=%b data=%h, want %b %h %0d %b %h",
                         c, out_valid, out_ctrl, occupancy, in_ready, out_data,
                         m1_valid(), m1_ctrl(), m1_occ(), m1_ready(), m1_data());
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_skid0();
        int accepted = 0;
        int cyc = 0;
        logic acc;
        in_valid0 = 1'b1; in_ctrl0 = 8'($urandom); in_data0 = rnd_data();
        while (accepted < 1000 && cyc < 8000) begin
            out_ready0 = $urandom_range(0, 1) != 0;
            #1;
            checks++;
            if (in_ready0 !== m0_ready()) begin
                errors++;
                $display("FAIL skid0_ready c=%0d: rdy=%b, want %b", cyc, in_ready0, m0_ready());
            end
            acc = in_valid0 && m0_ready();
            tick();
            cyc++;
            checks++;
            if (out_valid0 !== m0_valid() || out_ctrl0 !== m0_ctrl() || out_data0 !== m0_data() ||
                occupancy0 !== m0_occ() || occupancy0 > 2'd1) begin
                errors++;
                $display("FAIL skid0 c=%0d: valid=%b ctrl=%h occ=%0d data=%h, want %b %h %0d %h",
                         cyc, out_valid0, out_ctrl0, occupancy0, out_data0,
                         m0_valid(), m0_ctrl(), m0_occ(), m0_data());
            end
            if (acc) begin
                accepted++;
                in_ctrl0 = 8'($urandom); in_data0 = rnd_data();
                in_valid0 = ($urandom_range(0, 3) != 0);
            end else if (!in_valid0) begin
                in_valid0 = ($urandom_range(0, 3) != 0);
            end
        end
        in_valid0 = 1'b0;
        checks++;
        if (accepted < 1000) begin
            errors++;
            $display("FAIL skid0_timeout: accepted=%0d, want 1000", accepted);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_ctrl = 8'h60 + 8'(i); in_data = rnd_data();
            tick();
        end
        checks++;
        if (occupancy !== 2'd2) begin
            errors++;
            $display("FAIL rstmid_two: occ=%0d, want 2", occupancy);
        end
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h77;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'hA5 || out_data !== '0 || in_ready !== 1'b1 || occupancy !== 2'd0) begin
            errors++;
            $display("FAIL rstmid_reset: valid=%b ctrl=%h data=%h rdy=%b occ=%0d, want 0 a5 0 1 0",
                     out_valid, out_ctrl, out_data, in_ready, occupancy);
        end
        rst = 1'b0; flush = 1'b0;
        for (int v = 0; v < 4; v++) begin
            b = 8'hC0 + 8'(v);
            in_valid = 1'b1; in_ctrl = b; in_data = {16{b}};
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ctrl !== b || out_data !== {16{b}} || occupancy !== 2'd1) begin
                errors++;
                $display("FAIL rstmid_restart v=%0d: valid=%b ctrl=%h occ=%0d, want 1 %h 1",
                         v, out_valid, out_ctrl, occupancy, b);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = '0; in_data = '0;
        flush0 = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b0; in_ctrl0 = '0; in_data0 = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_random_skid();
        test_skid0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
